// File: rtl/mem_write_arbiter_if.sv
// mem_write_arbiter_if: requester / memory-port signal bundle for mem_write_arbiter.
//   Requester side : req0, req1, data0, data1, clear (into the arbiter)
//                    grant0, grant1 (back to the requesters)
//   Memory side    : write, addr[ADDR_W], wdata (to the memory driver)
//   Status / debug : memory_full, stop, current_state[2], next_state[2]
//   Modports: master (requesters / test environment), slave (the arbiter).
interface mem_write_arbiter_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              req0;
  logic              req1;
  logic              data0;
  logic              data1;
  logic              clear;
  logic              grant0;
  logic              grant1;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic              wdata;
  logic [1:0]        current_state;
  logic [1:0]        next_state;
  logic              memory_full;
  logic              stop;

  modport master (
    output req0, req1, data0, data1, clear,
    input  grant0, grant1, write, addr, wdata,
    input  current_state, next_state, memory_full, stop
  );

  modport slave (
    input  req0, req1, data0, data1, clear,
    output grant0, grant1, write, addr, wdata,
    output current_state, next_state, memory_full, stop
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: shares one serial-bit memory write port between two
// requesters. Each write walks IDLE -> GRANT -> WRITE -> IDLE; the write
// pointer advances after every write and the block parks in FULL (memory_full,
// stop) once location DEPTH-1 has been written, until clear restarts the fill.
//
// Ports:
//   clk  - rising-edge system clock
//   rst  - asynchronous active-low reset
//   bus  - mem_write_arbiter_if.slave: req0/req1, data0/data1, clear in;
//          grant0/grant1, write, addr, wdata, memory_full, stop,
//          current_state (registered) and next_state (combinational) out.
//
// Parameters:
//   ADDR_W - width of addr
//   DEPTH  - number of writable locations, 1..2**ADDR_W
//
// Build option:
//   MEM_WRITE_ARBITER_FIXED_PRIO_EN - when defined, req0 always wins a tie;
//   otherwise ties alternate (round robin), req0 winning the first one.
module mem_write_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input logic              clk,
  input logic              rst,
  mem_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WRITE = 2'b10,
    FULL  = 2'b11
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  state_e            state_nxt_c;

  // Registered outputs and their next values
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              write_q,  write_d;
  logic              wdata_q,  wdata_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              full_q,   full_d;
  logic              stop_q,   stop_d;

  // Most recently granted requester (0/1); selects the data bit in GRANT and,
  // in round-robin builds, is the pointer that decides the next tie.
  logic              owner_q,  owner_d;

  logic              req_any_c;
  logic              win_c;    // 0 = req0 wins, 1 = req1 wins

  assign req_any_c = bus.req0 | bus.req1;

  // Arbitration decision for the current IDLE cycle
`ifdef MEM_WRITE_ARBITER_FIXED_PRIO_EN
  assign win_c = ~bus.req0;
`else
  always_comb begin
    win_c = bus.req1;
    if (bus.req0 && bus.req1) begin
      win_c = ~owner_q;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt_c;
    end
  end

  // Next-state logic; clear in IDLE outranks any request
  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.clear && req_any_c) begin
          state_nxt_c = GRANT;
        end
      end
      GRANT: begin
        state_nxt_c = WRITE;
      end
      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_nxt_c = FULL;
        end else begin
          state_nxt_c = IDLE;
        end
      end
      FULL: begin
        if (bus.clear) begin
          state_nxt_c = IDLE;
        end
      end
      default: begin
        state_nxt_c = IDLE;
      end
    endcase
  end

  // Output next-values; grants and write are single-cycle pulses by default
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    write_d  = 1'b0;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    full_d   = full_q;
    stop_d   = stop_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          addr_d = '0;
        end else if (req_any_c) begin
          grant0_d = ~win_c;
          grant1_d = win_c;
          owner_d  = win_c;
        end
      end
      GRANT: begin
        // Data is captured here even if the requester already dropped req
        write_d = 1'b1;
        wdata_d = owner_q ? bus.data1 : bus.data0;
      end
      WRITE: begin
        // The pointer stops at the last location; only clear rewinds it
        if (addr_q == LAST_ADDR) begin
          full_d = 1'b1;
          stop_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      FULL: begin
        if (bus.clear) begin
          addr_d = '0;
          full_d = 1'b0;
          stop_d = 1'b0;
        end
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  // Output register; reset also aborts any write in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 1'b0;
      addr_q   <= '0;
      full_q   <= 1'b0;
      stop_q   <= 1'b0;
      owner_q  <= 1'b1;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      full_q   <= full_d;
      stop_q   <= stop_d;
      owner_q  <= owner_d;
    end
  end

  assign bus.grant0        = grant0_q;
  assign bus.grant1        = grant1_q;
  assign bus.write         = write_q;
  assign bus.wdata         = wdata_q;
  assign bus.addr          = addr_q;
  assign bus.memory_full   = full_q;
  assign bus.stop          = stop_q;
  assign bus.current_state = state_q;
  assign bus.next_state    = state_nxt_c;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb_mem_write_arbiter: directed bench for mem_write_arbiter (ADDR_W=4, DEPTH=4).
// Expected grants and writes are queued as stimulus is issued; a monitor forked
// from the main sequence pops and compares on every grant/write pulse.
module tb_mem_write_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wdata;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_write_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_write_arbiter #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int  checks   = 0;
  int  failures = 0;
  int  exp_grant_q[$];
  wr_t exp_write_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples on the falling edge
  task automatic monitor;
    int  g;
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.grant0 || bus.grant1) begin
          if (exp_grant_q.size() == 0) begin
            check("unexpected_grant", 32'({bus.grant1, bus.grant0}), 32'd0);
          end else begin
            g = exp_grant_q.pop_front();
            check("grant_id", 32'({bus.grant1, bus.grant0}), (g == 0) ? 32'd1 : 32'd2);
          end
        end
        if (bus.write) begin
          if (exp_write_q.size() == 0) begin
            check("unexpected_write", 32'(bus.write), 32'd0);
          end else begin
            e = exp_write_q.pop_front();
            check("write_addr", 32'(bus.addr), 32'(e.addr));
            check("write_data", 32'(bus.wdata), 32'(e.wdata));
          end
        end
      end
    end
  endtask

  // One isolated write by requester 'who' with data bit d, expected at address a
  task automatic do_write(input int who, input logic d, input logic [ADDR_W-1:0] a);
    wr_t e;
    e.addr  = a;
    e.wdata = d;
    exp_grant_q.push_back(who);
    exp_write_q.push_back(e);
    if (who == 0) begin
      bus.req0 = 1'b1; bus.data0 = d;
    end else begin
      bus.req1 = 1'b1; bus.data1 = d;
    end
    tick;                       // GRANT
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick;                       // WRITE
    tick;                       // back to IDLE
  endtask

  initial begin
    int  exp_g[4];
    logic [3:0] exp_d;
    wr_t e;

    rst       = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 1'b0;
    bus.data1 = 1'b0;
    bus.clear = 1'b0;

    fork
      monitor();
    join_none

    // Reset state
    tick;
    tick;
    check("rst_state", 32'(bus.current_state), 32'd0);
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_grants", 32'({bus.grant1, bus.grant0}), 32'd0);
    check("rst_full", 32'({bus.memory_full, bus.stop}), 32'd0);
    rst = 1'b1;
    tick;

    // Single request: latency grant N+1, write N+2, IDLE N+3
    e.addr = 4'd0; e.wdata = 1'b1;
    exp_grant_q.push_back(0);
    exp_write_q.push_back(e);
    bus.req0 = 1'b1; bus.data0 = 1'b1;
    tick;
    check("single_grant_state", 32'(bus.current_state), 32'd1);
    check("single_grant0", 32'(bus.grant0), 32'd1);
    bus.req0 = 1'b0;
    tick;
    check("single_write_state", 32'(bus.current_state), 32'd2);
    check("single_write", 32'(bus.write), 32'd1);
    check("single_addr", 32'(bus.addr), 32'd0);
    check("single_wdata", 32'(bus.wdata), 32'd1);
    tick;
    check("single_idle_state", 32'(bus.current_state), 32'd0);
    check("single_next_addr", 32'(bus.addr), 32'd1);
    bus.data0 = 1'b0;

    // Fresh reset, then contention fill to FULL
    rst = 1'b0;
    tick;
    rst = 1'b1;
`ifdef MEM_WRITE_ARBITER_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
    exp_d = 4'b1111;
`else
    exp_g = '{0, 1, 0, 1};
    exp_d = 4'b0101;            // bit i = wdata of write i
`endif
    for (int i = 0; i < 4; i++) begin
      e.addr  = ADDR_W'(i);
      e.wdata = exp_d[i];
      exp_grant_q.push_back(exp_g[i]);
      exp_write_q.push_back(e);
    end
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 1'b1; bus.data1 = 1'b0;
    repeat (15) tick;           // 4 writes x 3 cycles, then FULL with reqs held
    check("full_state", 32'(bus.current_state), 32'd3);
    check("full_flag", 32'(bus.memory_full), 32'd1);
    check("full_stop", 32'(bus.stop), 32'd1);
    check("full_addr", 32'(bus.addr), 32'd3);
    check("full_next_state_hold", 32'(bus.next_state), 32'd3);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.clear = 1'b1;
    #1;
    check("full_next_state_clear", 32'(bus.next_state), 32'd0);
    tick;
    bus.clear = 1'b0;
    check("clear_state", 32'(bus.current_state), 32'd0);
    check("clear_addr", 32'(bus.addr), 32'd0);
    check("clear_flags", 32'({bus.memory_full, bus.stop}), 32'd0);

    // Two writes, then clear during GRANT is ignored
    do_write(0, 1'b1, 4'd0);
    do_write(1, 1'b1, 4'd1);
    e.addr = 4'd2; e.wdata = 1'b1;
    exp_grant_q.push_back(0);
    exp_write_q.push_back(e);
    bus.req0 = 1'b1; bus.data0 = 1'b1;
    tick;                       // GRANT
    bus.clear = 1'b1;
    bus.req0  = 1'b0;           // dropping req does not cancel
    tick;                       // WRITE
    bus.clear = 1'b0;
    check("gclear_write_state", 32'(bus.current_state), 32'd2);
    check("gclear_write_addr", 32'(bus.addr), 32'd2);
    tick;
    check("gclear_idle_addr", 32'(bus.addr), 32'd3);

    // Clear with req0 in IDLE: clear wins, no grant
    bus.clear = 1'b1; bus.req0 = 1'b1; bus.data0 = 1'b0;
    tick;
    check("iclear_state", 32'(bus.current_state), 32'd0);
    check("iclear_addr", 32'(bus.addr), 32'd0);
    check("iclear_no_grant", 32'(bus.grant0), 32'd0);
    bus.clear = 1'b0;
    e.addr = 4'd0; e.wdata = 1'b0;
    exp_grant_q.push_back(0);
    exp_write_q.push_back(e);
    tick;                       // GRANT from held req0
    bus.req0 = 1'b0;
    tick;                       // WRITE
    tick;                       // IDLE, addr=1

    // Reset in the middle of WRITE aborts it asynchronously
    exp_grant_q.push_back(1);
    bus.req1 = 1'b1; bus.data1 = 1'b1;
    tick;                       // GRANT
    bus.req1 = 1'b0;
    tick;                       // WRITE
    check("mid_write_high", 32'(bus.write), 32'd1);
    check("mid_write_addr", 32'(bus.addr), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_write", 32'(bus.write), 32'd0);
    check("abort_addr", 32'(bus.addr), 32'd0);
    check("abort_state", 32'(bus.current_state), 32'd0);
    check("abort_flags", 32'({bus.memory_full, bus.stop, bus.grant1, bus.grant0}), 32'd0);
    tick;
    rst = 1'b1;
    repeat (3) tick;

    check("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
    check("write_queue_drained", 32'(exp_write_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
